// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word-to-byte serializer feeding a byte-wide UART transmitter
// Define TXW_MSB_FIRST_EN to send the most-significant byte first (default: LSB first).
module uart_word_tx #(
  parameter int NBITS = 32,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] tx_Data,
  input  logic             tx_start,
  input  logic             byte_done,
  output logic [DBITS-1:0] o_byte,
  output logic             o_byte_start,
  output logic             tx_done,
  output logic             busy
);

  localparam int NBYTES = NBITS / DBITS;
  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shreg_next;
  logic [CW-1:0]    cnt;

`ifdef TXW_MSB_FIRST_EN
  assign shreg_next = shreg << DBITS;

  function automatic logic [DBITS-1:0] pick(input logic [NBITS-1:0] w);
    return w[NBITS-1 -: DBITS];
  endfunction
`else
  assign shreg_next = shreg >> DBITS;

  function automatic logic [DBITS-1:0] pick(input logic [NBITS-1:0] w);
    return w[DBITS-1:0];
  endfunction
`endif

  // o_byte is loaded on entry to SEND so it is already valid in the o_byte_start cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      o_byte       <= '0;
      o_byte_start <= 1'b0;
      tx_done      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      o_byte_start <= 1'b0;
      tx_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shreg        <= tx_Data;
            cnt          <= '0;
            busy         <= 1'b1;
            o_byte       <= pick(tx_Data);
            o_byte_start <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (byte_done) begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              tx_done <= 1'b1;
              state   <= DONE;
            end else begin
              o_byte       <= pick(shreg_next);
              o_byte_start <= 1'b1;
              state        <= SEND;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - randomized self-checking bench for uart_word_tx
// Honours TXW_MSB_FIRST_EN for byte-order expectations.
module tb_uart_word_tx;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tx_Data;
  logic        tx_start;
  logic        byte_done;
  logic [7:0]  o_byte;
  logic        o_byte_start;
  logic        tx_done;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_done = 0;
  int ndone = 0;
  int busy_cyc = 0;
  logic [7:0] sent[$];
  logic [7:0] expq[$];

  int uart_dly = 3;
  int uart_cnt = 0;
  bit bd_force = 0;
  bit bd_on_start = 0;

  // behavioural model state
  bit         m_busy = 0;
  bit         m_wait = 0;
  bit         m_start = 0;
  bit         m_done = 0;
  logic [7:0] m_byte = '0;
  logic [7:0] m_q[$];

  uart_word_tx #(.NBITS(32), .DBITS(8)) dut (
    .clk(clk), .reset(reset), .tx_Data(tx_Data), .tx_start(tx_start),
    .byte_done(byte_done), .o_byte(o_byte), .o_byte_start(o_byte_start),
    .tx_done(tx_done), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
`ifdef TXW_MSB_FIRST_EN
    return w[8*(NB-1-i) +: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A word is a queue of bytes; each byte is offered, awaited, then the next follows.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_wait = 0; m_start = 0; m_done = 0; m_byte = '0; m_q.delete();
    end else begin
      bit n_start, n_done;
      n_start = 0; n_done = 0;
      if (!m_busy) begin
        if (tx_start) begin
          for (int i = 0; i < NB; i++) m_q.push_back(byte_of(tx_Data, i));
          m_byte = m_q.pop_front();
          n_start = 1;
          m_busy = 1;
        end
      end else if (m_done) begin
        m_busy = 0;
      end else if (m_wait && byte_done) begin
        m_wait = 0;
        if (m_q.size() == 0) n_done = 1;
        else begin
          m_byte = m_q.pop_front();
          n_start = 1;
        end
      end
      if (m_start) m_wait = 1;
      m_start = n_start;
      m_done = n_done;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("o_byte", 32'(o_byte), 32'(m_byte));
      chk("o_byte_start", 32'(o_byte_start), 32'(m_start));
      chk("tx_done", 32'(tx_done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_busy));
      if (o_byte_start === 1'b1) sent.push_back(o_byte);
      if (tx_done === 1'b1) begin ndone++; t_done = cyc; end
      if (busy === 1'b1) busy_cyc++;
    end
  end

  // UART stand-in: byte_done uart_dly cycles after each o_byte_start, plus injected pulses
  initial begin
    byte_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      byte_done = 1'b0;
      if (reset !== 1'b1) uart_cnt = 0;
      else begin
        if (uart_cnt > 0) begin
          uart_cnt--;
          if (uart_cnt == 0) byte_done = 1'b1;
        end
        if (o_byte_start === 1'b1) begin
          uart_cnt = uart_dly;
          if (bd_on_start) byte_done = 1'b1;
        end
        if (bd_force) byte_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin tick(); n++; end
  endtask

  task automatic send_word(input logic [31:0] w);
    tx_Data = w;
    tx_start = 1'b1;
    t_acc = cyc;
    tick();
    tx_start = 1'b0;
    tx_Data = $urandom;
  endtask

  task automatic wait_done(input int target, input string name, input bit noise);
    int n = 0;
    while (ndone < target && n < 300) begin
      tick();
      n++;
      tx_start = 1'b0;
      if (noise && ndone < target && busy === 1'b1 && ($urandom % 4 == 0)) begin
        tx_Data = $urandom;
        tx_start = 1'b1;
      end
    end
    tx_start = 1'b0;
    chk(name, 32'(ndone), 32'(target));
  endtask

  task automatic check_bytes(input string name);
    chk({name, "_count"}, 32'(sent.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < sent.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(sent[i]), 32'(expq[i]));
  endtask

  task automatic clear_log();
    sent.delete();
    ndone = 0;
    busy_cyc = 0;
  endtask

  initial begin
    logic [31:0] w;
    int gap;
    reset = 1'b0;
    tx_start = 1'b0;
    tx_Data = '0;

    // reset state
    tick(); tick();
    chk("rst_o_byte", 32'(o_byte), 32'h0);
    chk("rst_o_byte_start", 32'(o_byte_start), 32'h0);
    chk("rst_tx_done", 32'(tx_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(); tick();

    // basic word, fixed 3-cycle byte time
    clear_log();
    uart_dly = 3;
    send_word(32'h44332211);
    wait_done(1, "t2_done", 0);
    repeat (5) tick();
`ifdef TXW_MSB_FIRST_EN
    expq = '{8'h44, 8'h33, 8'h22, 8'h11};
`else
    expq = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    check_bytes("t2");
    chk("t2_ndone", 32'(ndone), 32'd1);
    chk("t2_latency", 32'(t_done - t_acc), 32'd17);
    chk("t2_busy_cycles", 32'(busy_cyc), 32'd17);

    // tx_start while busy and in the DONE cycle is dropped
    clear_log();
    send_word(32'h44332211);
    wait_cyc(t_acc + 5);
    tx_Data = 32'hDEADBEEF; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_cyc(t_acc + 17);
    chk("t4_in_done_cycle", 32'(tx_done), 32'd1);
    tx_Data = 32'hDEADBEEF; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (30) tick();
    check_bytes("t4");
    chk("t4_ndone", 32'(ndone), 32'd1);

    // spurious byte_done in IDLE and alongside every o_byte_start
    clear_log();
    repeat (3) begin bd_force = 1; tick(); bd_force = 0; tick(); end
    bd_on_start = 1;
    send_word(32'h44332211);
    wait_done(1, "t5_done", 0);
    bd_on_start = 0;
    repeat (5) tick();
    check_bytes("t5");
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_latency", 32'(t_done - t_acc), 32'd17);

    // back-to-back words
    clear_log();
    send_word(32'h00000002);
    wait_done(1, "t6_done1", 0);
    send_word(32'h00000003);
    wait_done(2, "t6_done2", 0);
    repeat (5) tick();
`ifdef TXW_MSB_FIRST_EN
    expq = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
`else
    expq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
`endif
    check_bytes("t6");

    // reset mid-WAIT of the second byte
    clear_log();
    send_word(32'h44332211);
    wait_cyc(t_acc + 7);
    reset = 1'b0;
    #1;
    chk("mid_rst_o_byte", 32'(o_byte), 32'h0);
    chk("mid_rst_o_byte_start", 32'(o_byte_start), 32'h0);
    chk("mid_rst_tx_done", 32'(tx_done), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick(); tick();
    reset = 1'b1;
    repeat (30) tick();
    chk("mid_rst_ndone", 32'(ndone), 32'd0);
    chk("mid_rst_sent", 32'(sent.size()), 32'd2);
    clear_log();
    send_word(32'hA1B2C3D4);
    wait_done(1, "post_rst_done", 0);
    repeat (3) tick();
    expq.delete();
    for (int i = 0; i < NB; i++) expq.push_back(byte_of(32'hA1B2C3D4, i));
    check_bytes("post_rst");

    // randomized words, byte times, idle gaps and noise
    for (int k = 0; k < 20; k++) begin
      uart_dly = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      repeat (gap) begin bd_force = $urandom_range(0, 1); tick(); end
      bd_force = 0;
      clear_log();
      w = $urandom;
      send_word(w);
      wait_done(1, "rnd_done", 1);
      expq.delete();
      for (int i = 0; i < NB; i++) expq.push_back(byte_of(w, i));
      check_bytes($sformatf("rnd%0d", k));
      chk("rnd_latency", 32'(t_done - t_acc), 32'(1 + NB * (1 + uart_dly)));
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
